// File: rtl/ram_ctrl_pkg.sv
// Shared types for the two-port RAM access controller.
// FSM state encoding and port identifiers.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant history
// is held by the parent so this block stays combinational.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  input  logic       i_en,
  output logic [1:0] o_grant,
  output logic       o_winner
);

  always_comb begin
    o_grant  = 2'b00;
    o_winner = PORT_A;
    if (i_en) begin
      unique case (i_req)
        2'b01: begin
          o_grant  = 2'b01;
          o_winner = PORT_A;
        end
        2'b10: begin
          o_grant  = 2'b10;
          o_winner = PORT_B;
        end
        2'b11: begin
          // tie goes to whoever was not served last
          o_winner = ~i_last_grant;
          o_grant  = i_last_grant ? 2'b01 : 2'b10;
        end
        default: begin
          o_grant  = 2'b00;
          o_winner = PORT_A;
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Shares one async-read single-port RAM between two requesters,
// sequencing each access as SETUP / EXEC / DONE.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_wr,
  output logic              ram_cs
);

  // one extra bit so MEM_DEPTH == 2**ADDR_W does not wrap to zero
  localparam logic [ADDR_W:0] W_DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  state_t            r_state;
  state_t            w_next;
  logic              r_last;
  logic              r_win;
  logic              r_we;
  logic              r_oor;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_win;
  logic              w_arb_en;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_oor;
  logic              w_setup;
  logic              w_exec;
  logic              w_done;

  assign w_req    = {b_req, a_req};
  assign w_arb_en = (r_state == ST_IDLE);

  rr_arb2 u_arb (
    .i_req        (w_req),
    .i_last_grant (r_last),
    .i_en         (w_arb_en),
    .o_grant      (w_grant),
    .o_winner     (w_win)
  );

  assign w_sel_we    = (w_win == PORT_B) ? b_we    : a_we;
  assign w_sel_addr  = (w_win == PORT_B) ? b_addr  : a_addr;
  assign w_sel_wdata = (w_win == PORT_B) ? b_wdata : a_wdata;
  assign w_sel_oor   = ({1'b0, w_sel_addr} >= W_DEPTH);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  w_next = (|w_grant) ? ST_SETUP : ST_IDLE;
      ST_SETUP: w_next = ST_EXEC;
      ST_EXEC:  w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last    <= PORT_B;
      r_win     <= PORT_A;
      r_we      <= 1'b0;
      r_oor     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_arb_en && (|w_grant)) begin
        r_win   <= w_win;
        r_last  <= w_win;
        r_we    <= w_sel_we;
        r_oor   <= w_sel_oor;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (w_exec && !r_we && !r_oor) begin
        if (r_win == PORT_B) r_b_rdata <= ram_dout;
        else                 r_a_rdata <= ram_dout;
      end
    end
  end

  assign w_setup = (r_state == ST_SETUP);
  assign w_exec  = (r_state == ST_EXEC);
  assign w_done  = (r_state == ST_DONE);

  // strobes decode from state so reset clears them asynchronously
  assign a_gnt  = w_setup && (r_win == PORT_A);
  assign b_gnt  = w_setup && (r_win == PORT_B);
  assign a_done = w_done && (r_win == PORT_A);
  assign b_done = w_done && (r_win == PORT_B);
  assign a_err  = a_done && r_oor;
  assign b_err  = b_done && r_oor;

  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;
  assign ram_addr = r_addr;
  assign ram_din  = r_wdata;
  assign ram_cs   = (w_setup || w_exec || w_done) && !r_oor;
  assign ram_wr   = w_exec && r_we && !r_oor;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural RAM,
// plus a MEM_DEPTH=512 instance for range rejection.
module tb_ram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       a_req, a_we, b_req, b_we;
  logic [9:0] a_addr, b_addr, ram_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [7:0] ram_din, ram_dout;
  logic       a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic       ram_wr, ram_cs;

  logic       c_a_req, c_a_we, c_b_req, c_b_we;
  logic [9:0] c_a_addr, c_b_addr, c_ram_addr;
  logic [7:0] c_a_wdata, c_b_wdata, c_a_rdata, c_b_rdata;
  logic [7:0] c_ram_din, c_ram_dout;
  logic       c_a_gnt, c_a_done, c_a_err, c_b_gnt, c_b_done, c_b_err;
  logic       c_ram_wr, c_ram_cs;

  logic [7:0] mem [0:1023];
  assign ram_dout = mem[ram_addr];
  always @(posedge clk)
    if (ram_cs && ram_wr) mem[ram_addr] <= ram_din;

  ram_access_ctrl #(.ADDR_W(10), .DATA_W(8), .MEM_DEPTH(1024)) u_dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_wr(ram_wr), .ram_cs(ram_cs)
  );

  ram_access_ctrl #(.ADDR_W(10), .DATA_W(8), .MEM_DEPTH(512)) u_dut512 (
    .clk(clk), .rst(rst),
    .a_req(c_a_req), .a_we(c_a_we), .a_addr(c_a_addr),
    .a_wdata(c_a_wdata), .a_gnt(c_a_gnt), .a_done(c_a_done),
    .a_err(c_a_err), .a_rdata(c_a_rdata),
    .b_req(c_b_req), .b_we(c_b_we), .b_addr(c_b_addr),
    .b_wdata(c_b_wdata), .b_gnt(c_b_gnt), .b_done(c_b_done),
    .b_err(c_b_err), .b_rdata(c_b_rdata),
    .ram_addr(c_ram_addr), .ram_din(c_ram_din), .ram_dout(c_ram_dout),
    .ram_wr(c_ram_wr), .ram_cs(c_ram_cs)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {a_gnt, b_gnt, a_done, b_done, ram_wr, ram_cs}
  task automatic ph(input string tag, input logic [5:0] exp);
    chk(tag, {26'b0, a_gnt, b_gnt, a_done, b_done, ram_wr, ram_cs},
        {26'b0, exp});
  endtask

  // {a_gnt, a_done, a_err, ram_wr, ram_cs} of the 512-word instance
  task automatic pc(input string tag, input logic [4:0] exp);
    chk(tag, {27'b0, c_a_gnt, c_a_done, c_a_err, c_ram_wr, c_ram_cs},
        {27'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $fatal(1, "FAIL timeout: bench did not finish");
  end

  initial begin
    rst = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    c_a_req = 0; c_a_we = 0; c_a_addr = '0; c_a_wdata = '0;
    c_b_req = 0; c_b_we = 0; c_b_addr = '0; c_b_wdata = '0;
    c_ram_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {a_gnt, b_gnt, a_done, b_done, a_err, b_err,
                    ram_wr, ram_cs}, 0);
    chk("rst_data", {a_rdata, b_rdata, ram_din, ram_addr}, 0);
    chk("rst_512", {c_a_gnt, c_a_done, c_ram_wr, c_ram_cs, c_a_rdata}, 0);
    rst = 1'b0;

    // A write 0x005 <= 0xA5, inputs scrambled after gnt
    a_req = 1; a_we = 1; a_addr = 10'h005; a_wdata = 8'hA5;
    tick(); ph("w_setup", 6'b100001);
    chk("w_setup_addr", ram_addr, 10'h005);
    a_req = 0; a_addr = 10'h123; a_wdata = 8'h00;
    tick(); ph("w_exec", 6'b000011);
    chk("w_exec_bus", {ram_addr, ram_din}, {10'h005, 8'hA5});
    tick(); ph("w_done", 6'b001001);
    chk("w_done_hold", {a_err, ram_addr, ram_din}, {1'b0, 10'h005, 8'hA5});
    tick(); ph("w_idle", 6'b000000);

    // A read 0x005
    a_req = 1; a_we = 0; a_addr = 10'h005;
    tick(); ph("r_setup", 6'b100001);
    a_req = 0;
    tick(); ph("r_exec", 6'b000001);
    tick(); ph("r_done", 6'b001001);
    chk("r_rdata", {a_err, a_rdata}, {1'b0, 8'hA5});
    tick(); ph("r_idle", 6'b000000);

    // B writes 0x3FF <= 0x5C, then holds req for three reads
    b_req = 1; b_we = 1; b_addr = 10'h3FF; b_wdata = 8'h5C;
    tick(); ph("bw_setup", 6'b010001);
    b_we = 0;
    tick(); ph("bw_exec", 6'b000011);
    tick(); ph("bw_done", 6'b000101);
    tick(); ph("bw_idle", 6'b000000);
    for (int k = 0; k < 3; k++) begin
      tick(); ph($sformatf("br%0d_setup", k), 6'b010001);
      if (k == 2) b_req = 0;
      tick(); ph($sformatf("br%0d_exec", k), 6'b000001);
      tick(); ph($sformatf("br%0d_done", k), 6'b000101);
      chk($sformatf("br%0d_rdata", k), {b_err, b_rdata, a_err},
          {1'b0, 8'h5C, 1'b0});
      tick(); ph($sformatf("br%0d_idle", k), 6'b000000);
    end

    // simultaneous held requests alternate A, B, A, B
    a_req = 1; a_we = 1; a_addr = 10'h010; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 10'h020; b_wdata = 8'h22;
    for (int k = 0; k < 4; k++) begin
      logic ea;
      ea = (k % 2 == 0);
      tick(); ph($sformatf("rr%0d_setup", k), {ea, !ea, 4'b0001});
      if (k == 3) begin a_req = 0; b_req = 0; end
      tick(); ph($sformatf("rr%0d_exec", k), 6'b000011);
      tick(); ph($sformatf("rr%0d_done", k), {2'b00, ea, !ea, 2'b01});
      tick(); ph($sformatf("rr%0d_idle", k), 6'b000000);
    end
    chk("rr_mem", {mem[10'h010], mem[10'h020]}, {8'h11, 8'h22});

    // reset in the EXEC cycle of a B write
    b_req = 1; b_we = 1; b_addr = 10'h030; b_wdata = 8'h77;
    tick(); ph("rs_setup", 6'b010001);
    b_req = 0;
    tick(); ph("rs_exec", 6'b000011);
    #1 rst = 1'b1;
    #1 ph("rs_async", 6'b000000);
    tick(); ph("rs_hold1", 6'b000000);
    tick(); ph("rs_hold2", 6'b000000);
    rst = 1'b0;
    a_req = 1; a_we = 0; a_addr = 10'h005;
    b_req = 1; b_we = 0; b_addr = 10'h3FF;
    tick(); ph("rs_tie_setup", 6'b100001);
    a_req = 0; b_req = 0;
    tick(); ph("rs_tie_exec", 6'b000001);
    tick(); ph("rs_tie_done", 6'b001001);
    chk("rs_tie_rdata", a_rdata, 8'hA5);
    tick(); ph("rs_tie_idle", 6'b000000);

    // 512-word instance: last in-range word, then rejected 0x200
    c_a_req = 1; c_a_we = 0; c_a_addr = 10'h1FF; c_ram_dout = 8'hEE;
    tick(); pc("c_edge_setup", 5'b10001);
    c_a_req = 0;
    tick(); pc("c_edge_exec", 5'b00001);
    tick(); pc("c_edge_done", 5'b01001);
    chk("c_edge_rdata", c_a_rdata, 8'hEE);
    tick();
    c_a_req = 1; c_a_we = 1; c_a_addr = 10'h200; c_a_wdata = 8'h99;
    tick(); pc("c_w_setup", 5'b10000);
    c_a_req = 0;
    tick(); pc("c_w_exec", 5'b00000);
    tick(); pc("c_w_done", 5'b01100);
    tick(); pc("c_w_idle", 5'b00000);
    c_a_req = 1; c_a_we = 0; c_a_addr = 10'h200; c_ram_dout = 8'h33;
    tick(); pc("c_r_setup", 5'b10000);
    c_a_req = 0;
    tick(); pc("c_r_exec", 5'b00000);
    tick(); pc("c_r_done", 5'b01100);
    chk("c_r_rdata", c_a_rdata, 8'hEE);
    tick(); pc("c_r_idle", 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
